mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
Memory-access stage of the 5-stage RV32I pipeline. It sits between the EX/MEM pipeline register and the MEM/WB pipeline register. It turns the latched EX/MEM contents into a data-memory request, waits for a variable-latency response and formats the load data. It stalls the upstream pipeline while a request is outstanding and flags misaligned or timed-out accesses.

Parameters:
TIMEOUT_CYCLES, 255, maximum wait cycles for dmem_ready_i before bus error; 0 disables the timeout.

Ports:
clock  in  1  pipeline clock
reset  in  1  asynchronous, active-low reset
ex_mem_data_i  in  ex_mem_data_t  fields used: alu_result[31:0], rs2_data[31:0], rd[4:0], pc_plus4[31:0]
ex_mem_control_i  in  ex_mem_control_t  fields used: mem_read, mem_write, mem_funct3[2:0], reg_write, wb_sel[1:0]
hold_i  in  1  global freeze from the hazard unit; the MEM/WB register will not capture this cycle
dmem_req_o  out  1  request valid
dmem_we_o  out  1  1 = store
dmem_addr_o  out  32  word-aligned address ({alu_result[31:2],2'b00})
dmem_be_o  out  4  byte enables
dmem_wdata_o  out  32  lane-replicated store data
dmem_ready_i  in  1  request accepted and completed; rdata valid in the same cycle
dmem_rdata_i  in  32  read word
mem_wb_data_o  out  mem_wb_data_t  alu_result, load_data, rd, pc_plus4
mem_wb_control_o  out  mem_wb_control_t  reg_write, wb_sel
stall_o  out  1  freeze PC, IF/ID, ID/EX and EX/MEM
misalign_o  out  1  misaligned access this cycle
bus_err_o  out  1  one-cycle pulse on timeout

Behaviour:
- Reset: state=IDLE, wait counter=0, rdata_q=0. While reset is active, all outputs are 0 (the struct outputs are '0).
- mem_op = mem_read | mem_write. If both are set, the access is treated as a load.
- Alignment: byte accesses are always aligned. Half accesses need addr[0]=0. Word accesses need addr[1:0]=0. On a misaligned access: no request, misalign_o=1, mem_wb_control_o.reg_write forced to 0, no stall.
- Store lanes:
  - SB: be = 1 << addr[1:0], wdata = {4{rs2[7:0]}}.
  - SH: be = addr[1] ? 1100 : 0011, wdata = {2{rs2[15:0]}}.
  - SW: be = 1111.
  - For loads, be reflects the access size and we=0.
- Load format: the lane is selected by addr[1:0]. LB and LH sign-extend. LBU and LHU zero-extend. LW passes the word through. Any other funct3 behaves as LW.
- FSM states:
  - IDLE:
    - No aligned mem_op: dmem_req_o=0, stall_o=0.
    - Aligned mem_op: dmem_req_o=1.
    - If dmem_ready_i=1 in the same cycle (zero-wait): load_data comes from dmem_rdata_i directly and stall_o=0. If hold_i=1, capture rdata into rdata_q and go to DONE; otherwise stay in IDLE.
    - If dmem_ready_i=0: stall_o=1, go to WAIT, counter=1.
  - WAIT:
    - dmem_req_o=1; address, data, be and we must stay stable (EX/MEM is frozen by stall_o). stall_o=1.
    - On dmem_ready_i: stall_o=0 and load_data=dmem_rdata_i. If hold_i=1, capture rdata into rdata_q and go to DONE; otherwise go to IDLE.
    - On timeout: when TIMEOUT_CYCLES≠0, the counter reaching TIMEOUT_CYCLES with no ready pulses bus_err_o for one cycle, drops dmem_req_o, drives load_data=0 with reg_write=0, sets stall_o=0 and goes to IDLE.
    - The counter saturates and does not wrap.
  - DONE:
    - No request is reissued; dmem_req_o=0 and load_data=rdata_q.
    - Leave for IDLE in the first cycle with hold_i=0; that cycle still presents rdata_q.
- mem_wb_data_o and mem_wb_control_o are combinational pass-through and format of the current EX/MEM contents. Latency is zero cycles beyond the memory wait states. The MEM/WB register performs the capture.
- A store completes exactly like a load, except that load_data is don't-care and reported as 0.
- Reset asserted mid-WAIT: return to IDLE immediately and drop dmem_req_o asynchronously. The outstanding request is abandoned.
- hold_i=1 in IDLE with no mem_op: no effect.

Decomposition:
- cpu_pkg gets:
  - mem_wb_data_t and mem_wb_control_t (if not already present)
  - funct3 constants F3_LB/LH/LW/LBU/LHU/SB/SH/SW
  - enum mem_state_t {IDLE, WAIT, DONE}
- One combinational sub-module, load_store_align, handles the be/wdata generation, load extension and misalign detection. The FSM and counter stay in mem_access_stage.

Test Plan:
1. Zero-wait LW, addr 0x1000, ready=1, rdata 0xDEADBEEF -> req=1 for one cycle, stall_o=0, load_data=0xDEADBEEF, be=1111.
2. LB addr 0x1003, rdata 0x80112233 -> dmem_addr 0x1000, load_data 0xFFFFFF80. Same access as LBU -> 0x00000080.
3. SH addr 0x1002, rs2 0x0000BEEF -> we=1, be=1100, wdata 0xBEEFBEEF. SH addr 0x1001 -> req=0, misalign_o=1, reg_write=0.
4. LW with ready after 3 wait cycles -> stall_o high for exactly 3 cycles, request stable throughout, load_data valid on the ready cycle, back to IDLE.
5. TIMEOUT_CYCLES=4 with ready never asserted -> bus_err_o pulses once after 4 wait cycles, stall_o drops, reg_write=0. Separately, a completing load with hold_i=1 for 2 cycles -> DONE, exactly one request total, rdata_q presented stably.
6. Reset pulled low during WAIT -> dmem_req_o and stall_o go to 0 without a clock edge. After release, state is IDLE and no request is issued until a new mem_op arrives.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Purpose  : Shared types and constants for the RV32I pipeline: the EX/MEM and
//            MEM/WB pipeline-register payloads, load/store funct3 encodings,
//            access-size helper and the memory-stage state enumeration.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    // EX/MEM pipeline register payload
    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] rs2_data;
        logic [4:0]  rd;
        logic [31:0] pc_plus4;
    } ex_mem_data_t;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic [2:0] mem_funct3;
        logic       reg_write;
        logic [1:0] wb_sel;
    } ex_mem_control_t;

    // MEM/WB pipeline register payload
    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] load_data;
        logic [4:0]  rd;
        logic [31:0] pc_plus4;
    } mem_wb_data_t;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] wb_sel;
    } mem_wb_control_t;

    // Load/store funct3 encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Access size encodings
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    // The low two funct3 bits carry the size for both loads and stores;
    // the unused encoding 2'b11 is handled as a word access.
    function automatic logic [1:0] access_size(input logic [2:0] funct3);
        logic [1:0] sz;
        case (funct3[1:0])
            F3_SB[1:0]:        sz = SZ_BYTE;
            F3_SH[1:0]:        sz = SZ_HALF;
            F3_SW[1:0], 2'b11: sz = SZ_WORD;
            default:           sz = SZ_WORD;
        endcase
        return sz;
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_store_align.sv
`default_nettype none
// ============================================================================
// Module   : load_store_align
// Purpose  : Purely combinational lane logic for the memory stage: byte
//            enables, lane-replicated store data, load lane selection with
//            sign/zero extension, and misalignment detection.
// Ports    : funct3_i    - access funct3 (load or store encoding)
//            addr_lo_i   - byte offset within the word (alu_result[1:0])
//            rs2_i       - raw store operand
//            rword_i     - raw 32-bit read word to be formatted
//            be_o        - byte enables for the access size/offset
//            wdata_o     - store data replicated across lanes
//            load_data_o - extended load result
//            misalign_o  - offset illegal for the access size (unqualified)
// Revision : 1.0 - initial release
// ============================================================================
module load_store_align
    import cpu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] rs2_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] load_data_o,
    output logic        misalign_o
);

    logic [1:0]  w_size;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_size = access_size(funct3_i);

    // Byte enables, store data and alignment depend only on size and offset.
    always_comb begin
        be_o       = 4'b1111;
        wdata_o    = rs2_i;
        misalign_o = 1'b0;
        case (w_size)
            SZ_BYTE: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{rs2_i[7:0]}};
            end
            SZ_HALF: begin
                be_o       = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o    = {2{rs2_i[15:0]}};
                misalign_o = addr_lo_i[0];
            end
            default: begin
                be_o       = 4'b1111;
                wdata_o    = rs2_i;
                misalign_o = |addr_lo_i;
            end
        endcase
    end

    // Lane extraction from the read word.
    always_comb begin
        case (addr_lo_i)
            2'd1:    w_byte = rword_i[15:8];
            2'd2:    w_byte = rword_i[23:16];
            2'd3:    w_byte = rword_i[31:24];
            default: w_byte = rword_i[7:0];
        endcase
        w_half = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];
    end

    // Extension; unknown funct3 encodings fall through as a full word.
    always_comb begin
        case (funct3_i)
            F3_LB:   load_data_o = {{24{w_byte[7]}}, w_byte};
            F3_LH:   load_data_o = {{16{w_half[15]}}, w_half};
            F3_LBU:  load_data_o = {24'd0, w_byte};
            F3_LHU:  load_data_o = {16'd0, w_half};
            F3_LW:   load_data_o = rword_i;
            default: load_data_o = rword_i;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_stage
// Purpose  : Memory-access stage of the 5-stage RV32I pipeline. Converts the
//            EX/MEM contents into a data-memory request, waits for a
//            variable-latency response, formats load data and stalls the
//            upstream pipeline while the request is outstanding.
// Ports    : clock/reset        - pipeline clock, async active-low reset
//            ex_mem_data_i      - alu_result, rs2_data, rd, pc_plus4
//            ex_mem_control_i   - mem_read/write, funct3, reg_write, wb_sel
//            hold_i             - global freeze; MEM/WB will not capture
//            dmem_*             - data-memory request/response interface
//            mem_wb_data_o      - alu_result, load_data, rd, pc_plus4
//            mem_wb_control_o   - reg_write, wb_sel
//            stall_o            - freeze PC, IF/ID, ID/EX and EX/MEM
//            misalign_o         - misaligned access this cycle
//            bus_err_o          - single-cycle pulse on response timeout
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_stage
    import cpu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
)(
    input  logic            clock,
    input  logic            reset,
    input  ex_mem_data_t    ex_mem_data_i,
    input  ex_mem_control_t ex_mem_control_i,
    input  logic            hold_i,
    output logic            dmem_req_o,
    output logic            dmem_we_o,
    output logic [31:0]     dmem_addr_o,
    output logic [3:0]      dmem_be_o,
    output logic [31:0]     dmem_wdata_o,
    input  logic            dmem_ready_i,
    input  logic [31:0]     dmem_rdata_i,
    output mem_wb_data_t    mem_wb_data_o,
    output mem_wb_control_t mem_wb_control_o,
    output logic            stall_o,
    output logic            misalign_o,
    output logic            bus_err_o
);

    localparam int unsigned CNT_W      = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    mem_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       rdata_q, rdata_d;

    logic        w_mem_op;
    logic        w_is_load;
    logic        w_is_store;
    logic        w_misalign_raw;
    logic        w_access_ok;
    logic [31:0] w_rword;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_load_fmt;

    logic        w_req;
    logic        w_stall;
    logic        w_bus_err;
    logic        w_show_data;
    logic        w_kill_wb;

    mem_wb_data_t    w_wb_data;
    mem_wb_control_t w_wb_ctrl;
    logic [31:0]     w_load_data;
    logic            w_misalign;

    // A simultaneous read and write is executed as a load.
    assign w_mem_op    = ex_mem_control_i.mem_read | ex_mem_control_i.mem_write;
    assign w_is_load   = ex_mem_control_i.mem_read;
    assign w_is_store  = ex_mem_control_i.mem_write & ~ex_mem_control_i.mem_read;
    assign w_access_ok = w_mem_op & ~w_misalign_raw;

    // While parked in DONE the captured word is the data source; the memory
    // bus is no longer driving a valid response then.
    assign w_rword = (state_q == DONE) ? rdata_q : dmem_rdata_i;

    load_store_align u_align (
        .funct3_i    (ex_mem_control_i.mem_funct3),
        .addr_lo_i   (ex_mem_data_i.alu_result[1:0]),
        .rs2_i       (ex_mem_data_i.rs2_data),
        .rword_i     (w_rword),
        .be_o        (w_be),
        .wdata_o     (w_wdata),
        .load_data_o (w_load_fmt),
        .misalign_o  (w_misalign_raw)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    // ------------------------------------------------------------------
    // Next state and request/stall control
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rdata_d     = rdata_q;
        w_req       = 1'b0;
        w_stall     = 1'b0;
        w_bus_err   = 1'b0;
        w_show_data = 1'b0;
        w_kill_wb   = 1'b0;

        case (state_q)
            IDLE: begin
                if (w_access_ok) begin
                    w_req = 1'b1;
                    if (dmem_ready_i) begin
                        // Zero-wait completion; only park the word if the
                        // MEM/WB register is frozen and would miss it.
                        w_show_data = 1'b1;
                        if (hold_i) begin
                            rdata_d = dmem_rdata_i;
                            state_d = DONE;
                        end
                    end else begin
                        w_stall = 1'b1;
                        cnt_d   = CNT_W'(1);
                        state_d = WAIT;
                    end
                end
            end

            WAIT: begin
                w_req   = 1'b1;
                w_stall = 1'b1;
                if (dmem_ready_i) begin
                    w_stall     = 1'b0;
                    w_show_data = 1'b1;
                    cnt_d       = '0;
                    if (hold_i) begin
                        rdata_d = dmem_rdata_i;
                        state_d = DONE;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (TIMEOUT_EN && (cnt_q >= TIMEOUT_VAL)) begin
                    // Give up: withdraw the request and retire the
                    // instruction without a register write.
                    w_req     = 1'b0;
                    w_stall   = 1'b0;
                    w_bus_err = 1'b1;
                    w_kill_wb = 1'b1;
                    cnt_d     = '0;
                    state_d   = IDLE;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            DONE: begin
                w_show_data = 1'b1;
                if (!hold_i) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Pass-through and formatting toward MEM/WB
    // ------------------------------------------------------------------
    assign w_misalign  = w_mem_op & w_misalign_raw;
    assign w_load_data = (w_show_data && w_is_load && !w_kill_wb) ? w_load_fmt : 32'd0;

    always_comb begin
        w_wb_data.alu_result = ex_mem_data_i.alu_result;
        w_wb_data.load_data  = w_load_data;
        w_wb_data.rd         = ex_mem_data_i.rd;
        w_wb_data.pc_plus4   = ex_mem_data_i.pc_plus4;
        w_wb_ctrl.reg_write  = ex_mem_control_i.reg_write & ~w_misalign & ~w_kill_wb;
        w_wb_ctrl.wb_sel     = ex_mem_control_i.wb_sel;
    end

    // ------------------------------------------------------------------
    // Outputs: all forced low while reset is asserted, which also drops an
    // outstanding request without waiting for a clock edge.
    // ------------------------------------------------------------------
    assign dmem_req_o       = reset & w_req;
    assign dmem_we_o        = reset & w_req & w_is_store;
    assign dmem_addr_o      = (reset && w_req) ? {ex_mem_data_i.alu_result[31:2], 2'b00} : 32'd0;
    assign dmem_be_o        = (reset && w_req) ? w_be : 4'd0;
    assign dmem_wdata_o     = (reset && w_req && w_is_store) ? w_wdata : 32'd0;
    assign stall_o          = reset & w_stall;
    assign misalign_o       = reset & w_misalign;
    assign bus_err_o        = reset & w_bus_err;
    assign mem_wb_data_o    = reset ? w_wb_data : '0;
    assign mem_wb_control_o = reset ? w_wb_ctrl : '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_stage
// Purpose  : Self-checking bench for mem_access_stage. A transaction-level
//            model predicts outputs for every driven cycle; directed
//            literal checks pin key values of the model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_stage;
    import cpu_pkg::*;

    localparam int TO = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    ex_mem_data_t    exd;
    ex_mem_control_t exc;
    logic            hold, ready;
    logic [31:0]     rdata;

    logic            d_req, d_we, d_stall, d_mis, d_berr;
    logic [31:0]     d_addr, d_wdata;
    logic [3:0]      d_be;
    mem_wb_data_t    wb_data;
    mem_wb_control_t wb_ctrl;

    mem_access_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .clock            (clk),
        .reset            (rst_n),
        .ex_mem_data_i    (exd),
        .ex_mem_control_i (exc),
        .hold_i           (hold),
        .dmem_req_o       (d_req),
        .dmem_we_o        (d_we),
        .dmem_addr_o      (d_addr),
        .dmem_be_o        (d_be),
        .dmem_wdata_o     (d_wdata),
        .dmem_ready_i     (ready),
        .dmem_rdata_i     (rdata),
        .mem_wb_data_o    (wb_data),
        .mem_wb_control_o (wb_ctrl),
        .stall_o          (d_stall),
        .misalign_o       (d_mis),
        .bus_err_o        (d_berr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, req);
        end
    endtask

    // ---------------- transaction-level model ----------------
    int          m_waited = 0, n_waited = 0;   // cycles spent waiting so far
    bit          m_held = 0, n_held = 0;       // a completed word is parked
    logic [31:0] m_word = 0, n_word = 0;

    bit          exp_valid = 0;
    bit          e_req, e_we, e_stall, e_mis, e_berr, e_rw, e_load_chk;
    logic [31:0] e_addr, e_wdata, e_load;
    logic [3:0]  e_be;

    function automatic logic [31:0] fmt(input logic [31:0] w, input logic [2:0] f3, input int off);
        logic [31:0] sh, b, h;
        sh = w >> (8 * off);
        b  = sh & 32'hFF;
        h  = sh & 32'hFFFF;
        case (f3)
            F3_LB:   return (b >= 32'h80)   ? b - 32'h100   : b;
            F3_LH:   return (h >= 32'h8000) ? h - 32'h10000 : h;
            F3_LBU:  return b;
            F3_LHU:  return h;
            default: return w;
        endcase
    endfunction

    task automatic model_eval();
        int          sz, off;
        bit          op, ld, st, al;
        logic [31:0] a;
        a   = exd.alu_result;
        off = int'(a % 4);
        op  = exc.mem_read || exc.mem_write;
        ld  = exc.mem_read;
        st  = op && !ld;
        case (exc.mem_funct3 % 4)
            0:       sz = 1;
            1:       sz = 2;
            default: sz = 4;
        endcase
        al = (off % sz) == 0;

        e_req = 0; e_we = 0; e_stall = 0; e_mis = 0; e_berr = 0; e_load_chk = 0;
        e_rw = exc.reg_write; e_addr = 0; e_wdata = 0; e_load = 0; e_be = 0;
        n_waited = m_waited; n_held = m_held; n_word = m_word;

        if (m_held) begin
            e_load_chk = 1;
            e_load     = ld ? fmt(m_word, exc.mem_funct3, off) : 32'd0;
            n_held     = hold;
        end else if (op && !al) begin
            e_mis = 1;
            e_rw  = 0;
        end else if (op) begin
            if (ready || m_waited < TO) begin
                e_req   = 1;
                e_we    = st;
                e_addr  = a - 32'(off);
                e_be    = (sz == 4) ? 4'hF : 4'((sz == 2 ? 3 : 1) << off);
                e_wdata = !st ? 32'd0 :
                          (sz == 1) ? 32'(exd.rs2_data[7:0])  * 32'h01010101 :
                          (sz == 2) ? 32'(exd.rs2_data[15:0]) * 32'h00010001 :
                                      exd.rs2_data;
            end
            if (ready) begin
                e_load_chk = 1;
                e_load     = ld ? fmt(rdata, exc.mem_funct3, off) : 32'd0;
                n_waited   = 0;
                if (hold) begin
                    n_held = 1;
                    n_word = rdata;
                end
            end else if (m_waited >= TO) begin
                e_berr     = 1;
                e_rw       = 0;
                e_load_chk = 1;
                e_load     = 0;
                n_waited   = 0;
            end else begin
                e_stall  = 1;
                n_waited = m_waited + 1;
            end
        end
    endtask

    // ---------------- per-cycle comparison ----------------
    always @(negedge clk) begin
        if (exp_valid) begin
            chk("req",       32'(d_req),             32'(e_req));
            chk("stall",     32'(d_stall),           32'(e_stall));
            chk("misalign",  32'(d_mis),             32'(e_mis));
            chk("bus_err",   32'(d_berr),            32'(e_berr));
            chk("reg_write", 32'(wb_ctrl.reg_write), 32'(e_rw));
            chk("wb_sel",    32'(wb_ctrl.wb_sel),    32'(exc.wb_sel));
            chk("alu_pass",  wb_data.alu_result,     exd.alu_result);
            chk("rd_pass",   32'(wb_data.rd),        32'(exd.rd));
            chk("pc_pass",   wb_data.pc_plus4,       exd.pc_plus4);
            if (e_req) begin
                chk("we",   32'(d_we), 32'(e_we));
                chk("addr", d_addr,    e_addr);
                chk("be",   32'(d_be), 32'(e_be));
                if (e_we) chk("wdata", d_wdata, e_wdata);
            end
            if (e_load_chk) chk("load_data", wb_data.load_data, e_load);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input bit r, input bit w, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] rs2, input bit rdy, input logic [31:0] word, input bit hld);
        @(posedge clk);
        #1;
        m_waited = n_waited; m_held = n_held; m_word = n_word;
        exc.mem_read   = r;
        exc.mem_write  = w;
        exc.mem_funct3 = f3;
        exc.reg_write  = 1'b1;
        exc.wb_sel     = r ? 2'b01 : 2'b00;
        exd.alu_result = addr;
        exd.rs2_data   = rs2;
        exd.rd         = addr[6:2] ^ 5'd9;
        exd.pc_plus4   = addr + 32'h100;
        ready = rdy; rdata = word; hold = hld;
        model_eval();
        exp_valid = 1'b1;
    endtask

    task automatic idle(input bit hld, input bit rdy);
        cyc(1'b0, 1'b0, F3_LW, 32'h0000_0040, 32'h0, rdy, 32'h5555_AAAA, hld);
    endtask

    initial begin
        int sc, bc, rc;
        exc = '0; exd = '0;
        exc.mem_read = 1'b1; exc.mem_funct3 = F3_LW; exd.alu_result = 32'h1000;
        hold = 1'b0; ready = 1'b1; rdata = 32'hFFFF_FFFF;

        // Reset state: every output low even with a live load presented.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req",   32'(d_req),   32'd0);
        chk("rst_stall", 32'(d_stall), 32'd0);
        chk("rst_other", 32'(|{wb_data, wb_ctrl, d_be, d_addr, d_wdata, d_we, d_mis, d_berr}), 32'd0);
        exc.mem_read = 1'b0;
        #2 rst_n = 1'b1;

        idle(1'b0, 1'b1);
        #1 chk("idle_req", 32'(d_req), 32'd0);
        idle(1'b1, 1'b0);   // hold with no memory op has no effect

        // 1: zero-wait LW
        cyc(1, 0, F3_LW, 32'h1000, 0, 1, 32'hDEADBEEF, 0);
        #1;
        chk("t1_req",   32'(d_req),   32'd1);
        chk("t1_stall", 32'(d_stall), 32'd0);
        chk("t1_load",  wb_data.load_data, 32'hDEADBEEF);
        chk("t1_be",    32'(d_be),    32'hF);
        idle(0, 0);
        #1 chk("t1_one_req", 32'(d_req), 32'd0);

        // 2: byte/half loads and lane selection
        cyc(1, 0, F3_LB, 32'h1003, 0, 1, 32'h80112233, 0);
        #1;
        chk("t2_addr", d_addr, 32'h1000);
        chk("t2_lb",   wb_data.load_data, 32'hFFFFFF80);
        cyc(1, 0, F3_LBU, 32'h1003, 0, 1, 32'h80112233, 0);
        #1 chk("t2_lbu", wb_data.load_data, 32'h00000080);
        cyc(1, 0, F3_LH,  32'h1002, 0, 1, 32'h80112233, 0);
        cyc(1, 0, F3_LHU, 32'h1000, 0, 1, 32'h80112233, 0);
        cyc(1, 0, 3'b011, 32'h1004, 0, 1, 32'h0BADF00D, 0);
        cyc(1, 1, F3_LW,  32'h1008, 32'h77, 1, 32'h13572468, 0);  // read+write acts as load

        // 3: stores and misalignment
        cyc(0, 1, F3_SH, 32'h1002, 32'h0000BEEF, 1, 0, 0);
        #1;
        chk("t3_we",    32'(d_we), 32'd1);
        chk("t3_be",    32'(d_be), 32'hC);
        chk("t3_wdata", d_wdata,   32'hBEEFBEEF);
        cyc(0, 1, F3_SH, 32'h1001, 32'h0000BEEF, 1, 0, 0);
        #1;
        chk("t3_mis_req", 32'(d_req),             32'd0);
        chk("t3_mis",     32'(d_mis),             32'd1);
        chk("t3_mis_rw",  32'(wb_ctrl.reg_write), 32'd0);
        cyc(0, 1, F3_SB, 32'h1001, 32'h123456A5, 1, 0, 0);
        cyc(0, 1, F3_SW, 32'h1004, 32'hCAFEBABE, 1, 0, 0);
        cyc(1, 0, F3_LW, 32'h1002, 0, 1, 32'h1, 0);
        cyc(1, 0, F3_LH, 32'h1003, 0, 1, 32'h1, 0);

        // 4: three wait states
        sc = 0;
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, F3_LW, 32'h2000, 0, 0, 32'hFFFF0000, 0);
            #1 sc += int'(d_stall);
        end
        cyc(1, 0, F3_LW, 32'h2000, 0, 1, 32'h12345678, 0);
        #1;
        sc += int'(d_stall);
        chk("t4_load", wb_data.load_data, 32'h12345678);
        chk("t4_stall_cycles", 32'(sc), 32'd3);
        idle(0, 0);
        #1 chk("t4_back_idle", 32'(d_req), 32'd0);

        // 5a: timeout
        sc = 0; bc = 0;
        for (int i = 0; i < 5; i++) begin
            cyc(1, 0, F3_LW, 32'h3000, 0, 0, 0, 0);
            #1;
            sc += int'(d_stall);
            bc += int'(d_berr);
        end
        chk("t5_to_stall", 32'(d_stall),           32'd0);
        chk("t5_to_req",   32'(d_req),             32'd0);
        chk("t5_to_rw",    32'(wb_ctrl.reg_write), 32'd0);
        idle(0, 0);
        #1 bc += int'(d_berr);
        chk("t5_stall_cycles", 32'(sc), 32'd4);
        chk("t5_berr_pulses",  32'(bc), 32'd1);

        // 5b: completion under hold parks the word in DONE
        rc = 0;
        cyc(1, 0, F3_LW, 32'h1000, 0, 1, 32'hCAFEF00D, 1);
        #1 rc += int'(d_req);
        cyc(1, 0, F3_LW, 32'h1000, 0, 0, 32'h0, 1);
        #1 begin rc += int'(d_req); chk("t5_done_load1", wb_data.load_data, 32'hCAFEF00D); end
        cyc(1, 0, F3_LW, 32'h1000, 0, 1, 32'h11111111, 0);
        #1 begin rc += int'(d_req); chk("t5_done_load2", wb_data.load_data, 32'hCAFEF00D); end
        chk("t5_one_req", 32'(rc), 32'd1);
        idle(0, 0);
        // one wait state, then ready under hold, formatted from the parked word
        cyc(1, 0, F3_LB, 32'h1001, 0, 0, 32'h0, 1);
        cyc(1, 0, F3_LB, 32'h1001, 0, 1, 32'h00009A00, 1);
        cyc(1, 0, F3_LB, 32'h1001, 0, 0, 32'hFFFFFFFF, 0);
        #1 chk("t5_done_lb", wb_data.load_data, 32'hFFFFFF9A);
        idle(0, 0);

        // 6: asynchronous reset during WAIT
        cyc(1, 0, F3_LW, 32'h4000, 0, 0, 0, 0);
        cyc(1, 0, F3_LW, 32'h4000, 0, 0, 0, 0);
        #1;
        chk("t6_wait_req",   32'(d_req),   32'd1);
        chk("t6_wait_stall", 32'(d_stall), 32'd1);
        #1;
        exp_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t6_async_req",   32'(d_req),   32'd0);
        chk("t6_async_stall", 32'(d_stall), 32'd0);
        exc.mem_read = 1'b0; exc.mem_write = 1'b0;
        m_waited = 0; n_waited = 0; m_held = 0; n_held = 0; m_word = 0; n_word = 0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        idle(0, 1);
        #1 chk("t6_post_req0", 32'(d_req), 32'd0);
        idle(0, 0);
        #1 chk("t6_post_req1", 32'(d_req), 32'd0);
        cyc(1, 0, F3_LW, 32'h4000, 0, 1, 32'h00C0FFEE, 0);
        #1 chk("t6_new_req", 32'(d_req), 32'd1);
        idle(0, 0);

        @(posedge clk);
        #1 exp_valid = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
